// File: rtl/md_issue_ctrl_if.sv
// rtl/md_issue_ctrl_if.sv - E-stage md request/response bundle between the pipeline and md_issue_ctrl
// master: the issue controller; slave: the pipeline/unit side that feeds it.
interface md_issue_ctrl_if;
  logic        Req;
  logic [3:0]  e_mdOp;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_usesMd;
  logic        busy;
  logic [31:0] inA;
  logic [31:0] inB;
  logic [3:0]  hluType;
  logic        unSigned;
  logic        dst;
  logic        write;
  logic        stall_D;
  logic        mdErr;

  modport master (
    input  Req, e_mdOp, e_rs, e_rt, d_usesMd, busy,
    output inA, inB, hluType, unSigned, dst, write, stall_D, mdErr
  );

  modport slave (
    output Req, e_mdOp, e_rs, e_rt, d_usesMd, busy,
    input  inA, inB, hluType, unSigned, dst, write, stall_D, mdErr
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - HI/LO multiply-divide issue controller at the D/E boundary
// Issues starts/writes to the md unit, mirrors its busy window, stalls D and flags divergence.
module md_issue_ctrl #(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input  logic           clk,
  input  logic           reset,
  md_issue_ctrl_if.master md
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Both latencies must lie in 1..15 to fit the 4-bit mirror counter.
  localparam logic [3:0] MUL_LD = 4'(MUL_CYC);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYC);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_md_err;
  logic       r_start_q;

  logic       w_is_mul;
  logic       w_is_div;
  logic       w_is_mt;
  logic       w_idle;
  logic       w_start;
  logic       w_write;
  logic       w_busy_err;

  assign w_is_mul = (md.e_mdOp == 4'd1) || (md.e_mdOp == 4'd2);
  assign w_is_div = (md.e_mdOp == 4'd3) || (md.e_mdOp == 4'd4);
  assign w_is_mt  = (md.e_mdOp == 4'd7) || (md.e_mdOp == 4'd8);
  assign w_idle   = (r_state == ST_IDLE);

  // An md op reaching E while occupied is dropped rather than issued.
  assign w_start = (w_is_mul || w_is_div) && !md.Req && w_idle;
  assign w_write = w_is_mt && !md.Req && w_idle;

  assign md.inA      = md.e_rs;
  assign md.inB      = md.e_rt;
  assign md.hluType  = !w_start ? 4'b0000 : (w_is_mul ? 4'b0001 : 4'b0010);
  assign md.write    = w_write;
  assign md.dst      = (md.e_mdOp == 4'd5) || (md.e_mdOp == 4'd7);
  assign md.unSigned = (md.e_mdOp == 4'd2) || (md.e_mdOp == 4'd4);
  assign md.stall_D  = md.d_usesMd && (w_start || !w_idle || md.busy);
  assign md.mdErr    = r_md_err;

  // Req freezes the unit, so the mirror freezes with it and skips checking.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!md.Req) begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            w_cnt_nxt   = w_is_mul ? MUL_LD : DIV_LD;
            w_state_nxt = ST_ARM;
          end
        end
        ST_ARM: begin
          w_cnt_nxt   = r_cnt - 4'd1;
          w_state_nxt = (r_cnt == 4'd1) ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  assign w_busy_err = !md.Req &&
                      ((!w_idle && !md.busy) ||
                       (w_idle && md.busy && !r_start_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_md_err  <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_start_q <= w_start;
      if (w_busy_err) begin
        r_md_err <= 1'b1;
      end
    end
  end

endmodule
